branch_resolver: RTL

Closes the loop on the IFU branch predictor. It records each prediction issued at fetch in an in-order queue and compares it with the outcome resolved in execute. It then drives the predictor's feedback write port (write enable, taken, 10-bit index) and, on a misprediction, a pipeline flush with the corrected PC. It sits between the IFU and the execute stage.

---
 rtl/brr_pkg.sv | 18 +
 rtl/brr_queue.sv | 63 ++++++
 rtl/branch_resolver.sv | 111 +++++++++++
 3 files changed

// File: rtl/brr_pkg.sv
// brr_pkg: shared types for the branch resolver.
// Queue entry, FSM state and PC step.
package brr_pkg;

   typedef struct packed {
      logic        taken;
      logic [31:0] pc;
      logic [31:0] target;
   } brr_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } brr_state_t;

   localparam int INSN_BYTES = 4;

endpackage

// File: rtl/brr_queue.sv
// brr_queue: circular in-order FIFO of predictions.
// Clear wins over push/pop; full is registered.
module brr_queue
   import brr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  brr_entry_t push_entry,
   input  logic       pop,
   input  logic       clear,
   output brr_entry_t head,
   output logic       full,
   output logic       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   brr_entry_t        mem [DEPTH];
   logic [PW-1:0]     head_ptr;
   logic [PW-1:0]     tail_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_nxt;

   assign head  = mem[head_ptr];
   assign empty = (count == '0);

   // occupancy after this edge; push and pop together cancel
   always_comb begin
      count_nxt = count + CW'(push) - CW'(pop);
   end

   // entry storage, no reset needed
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[tail_ptr] <= push_entry;
      end
   end

   // pointers, occupancy and full flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         full     <= 1'b0;
      end else if (clear) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         full     <= 1'b0;
      end else begin
         if (push) tail_ptr <= tail_ptr + 1'b1;
         if (pop)  head_ptr <= head_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks fetch predictions against execute.
// Drives predictor feedback, flush/redirect and a miss counter.
module branch_resolver
   import brr_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int INDX_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              brr_clock_in,
   input  logic              brr_reset_in,
   input  logic              brr_push_in,
   input  logic              brr_push_taken_in,
   input  logic [31:0]       brr_push_pc_in,
   input  logic [31:0]       brr_push_target_in,
   output logic              brr_full_out,
   input  logic              brr_res_valid_in,
   input  logic              brr_res_taken_in,
   input  logic [31:0]       brr_res_target_in,
   output logic              brr_fb_we_out,
   output logic              brr_fb_taken_out,
   output logic [INDX_W-1:0] brr_fb_indx_out,
   output logic              brr_flush_out,
   output logic [31:0]       brr_redirect_pc_out,
   output logic [CNT_W-1:0]  brr_mispred_count_out
);

   brr_state_t state;
   brr_state_t state_nxt;
   brr_entry_t head;
   brr_entry_t push_entry;
   logic       q_full;
   logic       q_empty;
   logic       run;
   logic       res_ok;
   logic       mis;
   logic       push_ok;
   logic [31:0] corr_pc;

   assign run = (state == RUN);

   // resolve and mispredict decision against the queue head
   always_comb begin
      res_ok  = brr_res_valid_in & run & ~q_empty;
      mis     = res_ok &
                ((head.taken ^ brr_res_taken_in) |
                 (head.taken & brr_res_taken_in &
                  (head.target != brr_res_target_in)));
      push_ok = brr_push_in & run & (~q_full | res_ok) & ~mis;
      corr_pc = brr_res_taken_in ? brr_res_target_in
                                 : head.pc + 32'(INSN_BYTES);
   end

   assign push_entry = '{taken:  brr_push_taken_in,
                         pc:     brr_push_pc_in,
                         target: brr_push_target_in};

   brr_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk        (brr_clock_in),
      .rst_n      (brr_reset_in),
      .push       (push_ok),
      .push_entry (push_entry),
      .pop        (res_ok),
      .clear      (mis),
      .head       (head),
      .full       (q_full),
      .empty      (q_empty)
   );

   assign brr_full_out = q_full;

   // FLUSH lasts exactly one cycle after a mispredict
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (mis) state_nxt = FLUSH;
         FLUSH:   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // state register
   always_ff @(posedge brr_clock_in or negedge brr_reset_in) begin
      if (!brr_reset_in) state <= RUN;
      else               state <= state_nxt;
   end

   // registered feedback, flush, redirect and saturating counter
   always_ff @(posedge brr_clock_in or negedge brr_reset_in) begin
      if (!brr_reset_in) begin
         brr_fb_we_out         <= 1'b0;
         brr_fb_taken_out      <= 1'b0;
         brr_fb_indx_out       <= '0;
         brr_flush_out         <= 1'b0;
         brr_redirect_pc_out   <= '0;
         brr_mispred_count_out <= '0;
      end else begin
         brr_fb_we_out    <= res_ok;
         brr_fb_taken_out <= res_ok & brr_res_taken_in;
         brr_fb_indx_out  <= res_ok ? head.pc[INDX_W-1:0] : '0;
         brr_flush_out    <= mis;
         brr_redirect_pc_out <= mis ? corr_pc : '0;
         if (mis && (brr_mispred_count_out != '1)) begin
            brr_mispred_count_out <= brr_mispred_count_out + 1'b1;
         end
      end
   end

endmodule
